// File: rtl/d5m_raw_axis_packer_if.sv
// AXI4-Stream video bus carrying one 12-bit raw Bayer pixel per beat.
// tuser marks the first pixel of a frame; tlast marks the last pixel of each line.
interface d5m_raw_axis_packer_if;
    logic        tvalid;
    logic        tready;
    logic [15:0] tdata;
    logic        tuser;
    logic        tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/d5m_raw_axis_packer.sv
// Packs the D5M raw pixel bus into an AXI4-Stream with frame/line markers.
// A one-pixel hold stage lets tlast ride on the last pixel; a show-ahead FIFO absorbs stalls.
module d5m_raw_axis_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRM_CNT_W  = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     enable,
    input  logic [11:0]              idata,
    input  logic                     ifval,
    input  logic                     ilval,
    d5m_raw_axis_packer_if.master    rgb_m_axis,
    input  logic                     ovf_clr,
    output logic                     ovf_flag,
    output logic [FRM_CNT_W-1:0]     frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of two >= 4");
    end

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [11:0] pix;
    } entry_t;

    logic          ifval_q;
    logic          ilval_q;
    logic          armed;
    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic          hold_vld;
    logic          hold_sof;
    logic [11:0]   hold_pix;
    logic          first_pix;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          fv_rise;
    logic          fv_fall;
    logic          lv_fall;
    logic          pix_vld;
    logic          fifo_vld;
    logic          full;
    logic          wr_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          frame_done;

    // After reset a rise only counts once ifval has been seen low, so a
    // frame already in flight at release is skipped entirely.
    assign fv_rise  = ifval & ~ifval_q & armed;
    assign fv_fall  = ~ifval & ifval_q;
    assign lv_fall  = ilval_q & ~ilval;
    assign pix_vld  = ifval & ilval;

    assign fifo_vld = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = fifo_vld & rgb_m_axis.tready;

    always_comb begin
        wr_req         = 1'b0;
        wr_entry       = '0;
        wr_entry.tuser = hold_sof;
        wr_entry.pix   = hold_pix;
        if (state == ST_ACTIVE && hold_vld) begin
            if (pix_vld) begin
                wr_req = 1'b1;
            end else if (lv_fall | fv_fall) begin
                // ifval dropping mid-line closes the line as well
                wr_req         = 1'b1;
                wr_entry.tlast = 1'b1;
            end
        end
    end

    // Full is judged on the pre-pop count: a same-cycle pop does not rescue the write.
    assign push    = wr_req & ~full;
    assign ovf_set = wr_req & full;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fv_rise && enable) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (ovf_set)      state_nxt = fv_fall ? ST_IDLE : ST_DROP;
                else if (fv_fall) state_nxt = ST_IDLE;
            end
            ST_DROP:   if (fv_fall) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign frame_done = (state == ST_ACTIVE) & fv_fall & ~ovf_set;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ifval_q <= 1'b0;
            ilval_q <= 1'b0;
            armed   <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            ifval_q <= ifval;
            ilval_q <= ilval;
            if (!ifval) armed <= 1'b1;
            state   <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_vld  <= 1'b0;
            hold_sof  <= 1'b0;
            hold_pix  <= '0;
            first_pix <= 1'b0;
        end else if (state == ST_IDLE) begin
            hold_vld  <= 1'b0;
            first_pix <= (state_nxt == ST_ACTIVE);
        end else if (state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
            if (pix_vld) begin
                hold_vld  <= 1'b1;
                hold_pix  <= idata;
                hold_sof  <= first_pix;
                first_pix <= 1'b0;
            end else if (lv_fall) begin
                hold_vld  <= 1'b0;
            end
        end else begin
            hold_vld  <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ovf_flag  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (ovf_set)      ovf_flag <= 1'b1;
            else if (ovf_clr) ovf_flag <= 1'b0;
            if (frame_done)   frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Payload is forced to zero while empty so an idle bus reads as all-zero.
    assign head              = mem[rd_ptr];
    assign rgb_m_axis.tvalid = fifo_vld;
    assign rgb_m_axis.tdata  = fifo_vld ? {4'b0, head.pix} : 16'h0;
    assign rgb_m_axis.tuser  = fifo_vld & head.tuser;
    assign rgb_m_axis.tlast  = fifo_vld & head.tlast;

endmodule

// File: tb/tb_d5m_raw_axis_packer.sv
// Drives a 16-deep and a 4-deep packer from the same camera stimulus and checks
// both every cycle against a queue model, plus literal beat expectations per scenario.
module tb_d5m_raw_axis_packer;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b1;
    logic [11:0] idata = '0;
    logic        ifval = 1'b0;
    logic        ilval = 1'b0;
    logic        tready = 1'b1;
    logic        ovf_clr = 1'b0;
    bit          tog = 1'b0;

    logic        ovf16, ovf4;
    logic [15:0] fc16, fc4;

    int n_chk = 0;
    int n_fail = 0;

    d5m_raw_axis_packer_if ax16 ();
    d5m_raw_axis_packer_if ax4 ();
    assign ax16.tready = tready;
    assign ax4.tready  = tready;

    d5m_raw_axis_packer dut16 (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .idata(idata),
        .ifval(ifval), .ilval(ilval), .rgb_m_axis(ax16),
        .ovf_clr(ovf_clr), .ovf_flag(ovf16), .frame_cnt(fc16)
    );

    d5m_raw_axis_packer #(.FIFO_DEPTH(4), .FRM_CNT_W(16)) dut4 (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .idata(idata),
        .ifval(ifval), .ilval(ilval), .rgb_m_axis(ax4),
        .ovf_clr(ovf_clr), .ovf_flag(ovf4), .frame_cnt(fc4)
    );

    always #5 ACLK = ~ACLK;

    logic        o_tv [2];
    logic        o_tu [2];
    logic        o_tl [2];
    logic        o_ovf [2];
    logic [15:0] o_td [2];
    logic [15:0] o_fc [2];
    assign o_tv[0] = ax16.tvalid;  assign o_tv[1] = ax4.tvalid;
    assign o_tu[0] = ax16.tuser;   assign o_tu[1] = ax4.tuser;
    assign o_tl[0] = ax16.tlast;   assign o_tl[1] = ax4.tlast;
    assign o_td[0] = ax16.tdata;   assign o_td[1] = ax4.tdata;
    assign o_ovf[0] = ovf16;       assign o_ovf[1] = ovf4;
    assign o_fc[0] = fc16;         assign o_fc[1] = fc4;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: camera rules in terms of a bounded queue ----------------
    int          mst [2];          // 0 idle, 1 capturing, 2 dropping rest of frame
    bit          mhv [2];
    bit          mhs [2];
    bit          mfirst [2];
    logic [11:0] mhp [2];
    logic [13:0] mbuf [2][32];
    int          mrd [2];
    int          mcnt [2];
    bit          movf [2];
    logic [15:0] mfc [2];
    bit          mfvq, mlvq, marm;

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    initial forever begin
        bit fvr, fvf, lvf, pix;
        bit wr, ov, popm;
        logic [13:0] ent;
        @(posedge ACLK or negedge ARESETN);
        if (!ARESETN) begin
            for (int i = 0; i < 2; i++) begin
                mst[i] = 0; mhv[i] = 0; mhs[i] = 0; mfirst[i] = 0; mhp[i] = '0;
                mrd[i] = 0; mcnt[i] = 0; movf[i] = 0; mfc[i] = '0;
            end
            mfvq = 0; mlvq = 0; marm = 0;
        end else begin
            fvr = ifval && !mfvq && marm;
            fvf = !ifval && mfvq;
            lvf = mlvq && !ilval;
            pix = ifval && ilval;
            for (int i = 0; i < 2; i++) begin
                wr = 0; ov = 0; ent = '0;
                popm = (mcnt[i] > 0) && tready;
                case (mst[i])
                    0: if (fvr && enable) begin mst[i] = 1; mfirst[i] = 1; end
                    1: begin
                        if (pix) begin
                            if (mhv[i]) begin wr = 1; ent = {mhs[i], 1'b0, mhp[i]}; end
                            mhv[i] = 1; mhp[i] = idata; mhs[i] = mfirst[i]; mfirst[i] = 0;
                        end else if ((lvf || fvf) && mhv[i]) begin
                            wr = 1; ent = {mhs[i], 1'b1, mhp[i]}; mhv[i] = 0;
                        end
                        if (wr && mcnt[i] == dep(i)) begin
                            wr = 0; ov = 1; mhv[i] = 0; mst[i] = fvf ? 0 : 2;
                        end else if (fvf) begin
                            mst[i] = 0; mfc[i] = mfc[i] + 16'd1; mhv[i] = 0;
                        end
                    end
                    default: if (fvf) mst[i] = 0;
                endcase
                if (ov) movf[i] = 1;
                else if (ovf_clr) movf[i] = 0;
                if (popm) begin mrd[i] = (mrd[i] + 1) % 32; mcnt[i]--; end
                if (wr) begin mbuf[i][(mrd[i] + mcnt[i]) % 32] = ent; mcnt[i]++; end
            end
            mfvq = ifval; mlvq = ilval;
            if (!ifval) marm = 1;
        end
    end

    // ---------------- per-cycle compare and beat log ----------------
    logic [15:0] lg_d [2][64];
    bit          lg_u [2][64];
    bit          lg_l [2][64];
    int          lg_n [2];

    initial forever begin
        logic [35:0] a, e;
        logic [13:0] h;
        @(negedge ACLK);
        for (int i = 0; i < 2; i++) begin
            if (mcnt[i] > 0) begin
                h = mbuf[i][mrd[i]];
                a = {o_tv[i], o_tu[i], o_tl[i], o_td[i], o_ovf[i], o_fc[i]};
                e = {1'b1, h[13], h[12], 4'h0, h[11:0], movf[i], mfc[i]};
            end else begin
                a = {o_tv[i], 18'h0, o_ovf[i], o_fc[i]};
                e = {1'b0, 18'h0, movf[i], mfc[i]};
            end
            chk((i == 0) ? "cycle_d16" : "cycle_d4", {28'h0, a}, {28'h0, e});
            if (ARESETN && o_tv[i] && tready && lg_n[i] < 64) begin
                lg_d[i][lg_n[i]] = o_td[i];
                lg_u[i][lg_n[i]] = o_tu[i];
                lg_l[i][lg_n[i]] = o_tl[i];
                lg_n[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
        if (tog) tready = ~tready;
    endtask

    task automatic clr_log();
        lg_n[0] = 0;
        lg_n[1] = 0;
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_d16"}, {ax16.tvalid, ax16.tuser, ax16.tlast, ax16.tdata, ovf16, fc16}, 0);
        chk({nm, "_d4"},  {ax4.tvalid, ax4.tuser, ax4.tlast, ax4.tdata, ovf4, fc4}, 0);
    endtask

    // One frame: rise with ilval low, h lines of w pixels, 8-cycle line gaps, then fall.
    task automatic send_frame(input int w, input int h, input int base,
                              input int clr_at, input int rst_at, input int en_off_at);
        int k;
        k = 0;
        ifval = 1'b1; ilval = 1'b0;
        tick();
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                ilval = 1'b1;
                idata = 12'(base + k);
                ovf_clr = (k == clr_at);
                if (k == en_off_at) enable = 1'b0;
                tick();
                ovf_clr = 1'b0;
                if (k == clr_at) begin
                    chk("ovf_set_beats_clr", ovf4, 1);
                    chk("ovf_clr_alone_d16", ovf16, 0);
                end
                if (k == rst_at) begin
                    ARESETN = 1'b0;
                    #1;
                    chk_zero_outputs("reset_midframe");
                    #2;
                    ARESETN = 1'b1;
                    clr_log();
                end
                k++;
            end
            ilval = 1'b0;
            repeat (8) tick();
        end
        ifval = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        lg_n[0] = 0; lg_n[1] = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_zero_outputs("reset");
        ARESETN = 1'b1;
        repeat (2) tick();

        // 4x3 frame, free-flowing output
        clr_log();
        send_frame(4, 3, 1, -1, -1, -1);
        repeat (4) tick();
        chk("t1_beats_d16", lg_n[0], 12);
        chk("t1_beats_d4", lg_n[1], 12);
        for (int j = 0; j < 12; j++) begin
            chk("t1_tdata", lg_d[0][j], j + 1);
            chk("t1_tuser", lg_u[0][j], (j == 0));
            chk("t1_tlast", lg_l[0][j], (j % 4 == 3));
        end
        chk("t1_frame_cnt", fc16, 1);

        // same frame with tready alternating
        clr_log();
        tog = 1'b1;
        send_frame(4, 3, 1, -1, -1, -1);
        tog = 1'b0; tready = 1'b1;
        repeat (8) tick();
        chk("t2_beats", lg_n[0], 12);
        for (int j = 0; j < 12; j++) begin
            chk("t2_tdata", lg_d[0][j], j + 1);
            chk("t2_tuser", lg_u[0][j], (j == 0));
            chk("t2_tlast", lg_l[0][j], (j % 4 == 3));
        end
        chk("t2_no_ovf", ovf16, 0);
        chk("t2_frame_cnt", fc16, 2);

        // overflow of the 4-deep FIFO with output stalled
        clr_log();
        tready = 1'b0;
        send_frame(8, 1, 'h10, -1, -1, -1);
        chk("t3_ovf_d4", ovf4, 1);
        chk("t3_fc_d4_held", fc4, 2);
        chk("t3_fc_d16", fc16, 3);
        chk("t3_no_beats_stalled", lg_n[1], 0);
        tready = 1'b1;
        repeat (12) tick();
        chk("t3_beats_d4", lg_n[1], 4);
        for (int j = 0; j < 4; j++) begin
            chk("t3_tdata_d4", lg_d[1][j], 'h10 + j);
            chk("t3_tuser_d4", lg_u[1][j], (j == 0));
            chk("t3_tlast_d4", lg_l[1][j], 0);
        end
        chk("t3_beats_d16", lg_n[0], 8);
        chk("t3_tlast_d16", lg_l[0][7], 1);

        // ovf_clr alone, then ovf_clr coinciding with a new overflow
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", ovf4, 0);
        tready = 1'b0;
        send_frame(8, 1, 'h40, 5, -1, -1);
        tready = 1'b1;
        repeat (12) tick();
        chk("t4_ovf_still_set", ovf4, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // reset in the middle of a frame, then a clean frame
        clr_log();
        send_frame(4, 3, 'h21, -1, 4, -1);
        chk("t5_no_beats_d16", lg_n[0], 0);
        chk("t5_no_beats_d4", lg_n[1], 0);
        chk("t5_fc_after_reset", fc16, 0);
        clr_log();
        send_frame(4, 3, 'h31, -1, -1, -1);
        repeat (4) tick();
        chk("t5_beats", lg_n[0], 12);
        chk("t5_first_tdata", lg_d[0][0], 'h31);
        chk("t5_first_tuser", lg_u[0][0], 1);
        chk("t5_last_tdata", lg_d[0][11], 'h3C);
        chk("t5_last_tlast", lg_l[0][11], 1);
        chk("t5_frame_cnt", fc16, 1);

        // enable low at the rise, then enable dropped mid-frame
        clr_log();
        enable = 1'b0;
        send_frame(4, 2, 'h50, -1, -1, -1);
        chk("t6_disabled_beats", lg_n[0], 0);
        chk("t6_disabled_fc", fc16, 1);
        enable = 1'b1;
        clr_log();
        send_frame(4, 2, 'h60, -1, -1, 2);
        enable = 1'b1;
        repeat (4) tick();
        chk("t6_beats", lg_n[0], 8);
        chk("t6_last_tdata", lg_d[0][7], 'h67);
        chk("t6_fc", fc16, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
